instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the word-aligned byte address fetched first after reset.
REQ-002 The block SHALL have parameter MEM_LATENCY, default 2, meaning the clock cycles from a read_address change to a stable instruction; legal range 1..15.
REQ-003 Port clk  input  1  rising-edge clock; the block SHALL use one clock.
REQ-004 Port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 Port enable  input  1  fetch permitted; sampled only in IDLE.
REQ-006 Port read_address  output  32  byte address to instruction memory; equals the internal PC register.
REQ-007 Port instruction  input  32  word returned by instruction memory for read_address.
REQ-008 Port redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 Port redirect_target  input  32  new byte PC, qualified by redirect_valid.
REQ-010 Port out_valid  output  1  out_instruction/out_pc valid toward decode.
REQ-011 Port out_ready  input  1  decode accepts this cycle.
REQ-012 Port out_instruction  output  32  captured instruction word.
REQ-013 Port out_pc  output  32  byte address of out_instruction.
REQ-014 Port out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
REQ-015 Port misaligned  output  1  sticky error: a redirect target had bits [1:0] != 0.

Function
REQ-016 The block SHALL implement the states IDLE, WAIT, VALID and HALT.
REQ-017 In IDLE with enable=1 the block SHALL enter WAIT and load the latency counter with MEM_LATENCY-1; with enable=0 it SHALL remain in IDLE.
REQ-018 In WAIT the counter SHALL decrement each cycle; at counter==0 the block SHALL capture instruction into out_instruction and read_address into out_pc, then enter VALID.
REQ-019 out_valid SHALL assert exactly MEM_LATENCY cycles after the cycle in which WAIT was entered, and only in VALID.
REQ-020 In VALID, outputs SHALL hold stable while out_ready=0.
REQ-021 A handshake (out_valid & out_ready) SHALL advance PC by 4 (wrapping 32'hFFFF_FFFC -> 0), reload the counter, and enter WAIT in the same edge; out_valid SHALL be 0 the next cycle.
REQ-022 redirect_valid SHALL have priority over all other events in IDLE, WAIT and VALID: PC <= redirect_target, counter reloaded, state WAIT, out_valid 0 next cycle, any in-flight or unaccepted word discarded.
REQ-023 A redirect coinciding with a handshake SHALL complete the handshake for the current word and then apply the redirect target rather than PC+4.
REQ-024 A redirect with redirect_target[1:0] != 0 SHALL set misaligned, leave the PC unchanged, and enter HALT.
REQ-025 HALT SHALL be left only by reset; in HALT out_valid SHALL be 0 and all inputs SHALL be ignored.
REQ-026 read_address SHALL change only on a clock edge, never combinationally from inputs.

Reset
REQ-027 While reset_n=0: state=IDLE, PC=read_address=RESET_PC, counter=0, out_valid=0, out_instruction=0, out_pc=0, misaligned=0.
REQ-028 Reset asserted mid-WAIT or mid-VALID SHALL discard the fetch immediately, without waiting for a clock edge.

Structure
REQ-029 The state encoding, WORD_BYTES=4 and the counter width SHALL reside in the shared mips package/include.
REQ-030 The latency counter SHALL be one sub-module, fetch_latency_counter (load, decrement, zero flag).

Verification
REQ-031 Reset, enable=1, MEM_LATENCY=2, out_ready=1 -> fetches at 0,4,8,12; each out_valid 2 cycles after WAIT entry; out_pc_plus4 = out_pc+4.
REQ-032 out_ready=0 for 5 cycles in VALID at pc 8 -> out_instruction/out_pc held; read_address stays 8; no PC advance.
REQ-033 redirect_valid=1, target 0x40, during WAIT for pc 4 -> word for 4 is never presented; next out_pc=0x40.
REQ-034 Handshake and redirect (target 0x80) in the same cycle at pc 0x10 -> 0x10 accepted once; next out_pc=0x80, not 0x14.
REQ-035 Redirect to 0x42 -> misaligned=1, HALT, out_valid stays 0 until reset_n pulse; after reset misaligned=0 and PC=RESET_PC.
REQ-036 PC preset via redirect to 0xFFFF_FFFC, then handshake -> next read_address=0; reset_n pulled low mid-WAIT -> out_valid 0 and read_address=RESET_PC before the next edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage:
// FSM state encoding, word size and latency counter width.
package instruction_fetch_pkg;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_VALID,
        S_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } fetch_word_t;

    function automatic logic misaligned_addr(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_latency_counter.sv
// Down-counter timing the instruction memory latency:
// load, decrement and zero flag.
module fetch_latency_counter
    import instruction_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             decrement,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to instruction memory, waits
// out the memory latency and hands words to decode via valid/ready.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [31:0] read_address,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misaligned
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MEM_LATENCY - 1);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [31:0]      pc;
    logic [31:0]      pc_next;
    logic             pc_load;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] count;
    logic             capture;
    logic             set_mis;
    fetch_word_t      held;

    fetch_latency_counter u_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (RELOAD),
        .decrement  (cnt_dec),
        .count      (count),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks everything except HALT; a redirect that coincides
    // with a handshake still consumes the presented word.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        pc_load    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        set_mis    = 1'b0;
        if ((state != S_HALT) && redirect_valid) begin
            if (misaligned_addr(redirect_target)) begin
                set_mis    = 1'b1;
                state_next = S_HALT;
            end else begin
                pc_load    = 1'b1;
                pc_next    = redirect_target;
                cnt_load   = 1'b1;
                state_next = S_WAIT;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (enable) begin
                        cnt_load   = 1'b1;
                        state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_zero) begin
                        capture    = 1'b1;
                        state_next = S_VALID;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                S_VALID: begin
                    if (out_ready) begin
                        pc_load    = 1'b1;
                        pc_next    = pc + 32'(WORD_BYTES);
                        cnt_load   = 1'b1;
                        state_next = S_WAIT;
                    end
                end
                S_HALT: begin
                    state_next = S_HALT;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            held       <= '0;
            misaligned <= 1'b0;
        end else begin
            if (pc_load) begin
                pc <= pc_next;
            end
            if (capture) begin
                held <= '{instruction: instruction, pc: pc};
            end
            if (set_mis) begin
                misaligned <= 1'b1;
            end
        end
    end

    assign read_address    = pc;
    assign out_valid       = (state == S_VALID);
    assign out_instruction = held.instruction;
    assign out_pc          = held.pc;
    assign out_pc_plus4    = held.pc + 32'(WORD_BYTES);

endmodule
